router_port_tx: RTL and testbench
=================================

Name: router_port_tx

Overview:
Serial packet transmitter for one router input port. It drives the frame_n/valid_n/din triple of a single router input lane from a parallel byte interface. The host pushes packet bytes into an internal FIFO, then issues a start command with a 4-bit destination. The block serializes address, pad and payload in the router's input protocol. Sixteen instances, one per lane, form the stimulus/ingress front end of the 16x16 router.

Parameters:
DATA_W, 8, payload byte width in bits (serialized LSB first)
DEPTH, 16, payload FIFO entries (power of 2, >=2)
PAD_CYCLES, 5, pad cycles between address and payload

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  push {wr_last, wr_data} into FIFO
wr_data  input  DATA_W  payload byte
wr_last  input  1  marks final byte of a packet
wr_full  output  1  FIFO full (registered)
tx_start  input  1  start-packet request, sampled only when tx_busy=0
tx_addr  input  4  destination output port for the packet
tx_busy  output  1  high from the cycle after start acceptance until the cycle pkt_done pulses
pkt_done  output  1  one-cycle pulse after the last payload bit
err_ovf  output  1  sticky: a write was dropped because the FIFO was full
frame_n  output  1  to router frame_n[i], active low
valid_n  output  1  to router valid_n[i], active low
din  output  1  to router din[i]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset values: frame_n=1, valid_n=1, din=0, tx_busy=0, pkt_done=0, err_ovf=0, wr_full=0. Reset empties the FIFO and puts the FSM in IDLE.
- Reset mid-packet aborts the packet: frame_n and valid_n go high asynchronously, and the next packet starts clean.
- All serial outputs are registered.
- FIFO: DEPTH x (DATA_W+1) bits, with a count of width clog2(DEPTH+1).
  - A write is accepted only if count<DEPTH at the clock edge.
  - A pop in the same cycle does not free space for that cycle's write.
  - A dropped write sets err_ovf. err_ovf clears only on reset.
  - Simultaneous accepted write and pop leaves count unchanged.
- FSM states: IDLE, ADDR, PAD, DATA, DONE.
- IDLE:
  - frame_n=1, valid_n=1, din=0.
  - tx_start=1 latches tx_addr and moves to ADDR.
  - tx_start while tx_busy=1 is ignored.
- ADDR: exactly 4 cycles. frame_n=0, valid_n=1, din=addr[k] for k=0..3, LSB first. The first address bit appears the cycle after tx_start is sampled.
- PAD: exactly PAD_CYCLES cycles. frame_n=0, valid_n=1, din=1.
- DATA:
  - At each byte boundary, if the FIFO is non-empty, pop one entry into the shift register.
  - The byte is then driven for DATA_W consecutive cycles with valid_n=0, din=shift[0], LSB first.
  - On the final bit of a byte whose last flag is set, frame_n=1 in that same cycle; then go to DONE.
  - Back-to-back bytes have no gap when the FIFO is non-empty.
- Underrun: FIFO empty at a byte boundary.
  - The block drives frame_n=0, valid_n=1, din=0 and waits. No bits are skipped or repeated.
  - Bytes are popped whole, so an underrun never splits a byte.
- tx_start with an empty FIFO is legal. Address and pad are sent, then the block waits in underrun.
- A packet ends only on a last-flagged byte. A zero-length packet is not supported.
- DONE: one cycle. pkt_done=1, frame_n=1, valid_n=1, din=0, tx_busy=0. Then IDLE.
- Next-packet timing: tx_start may be sampled in the DONE cycle. In that case ADDR begins the next cycle, so the minimum gap with frame_n=1 is 1 cycle.
- Packet latency (full FIFO, N bytes): 4 + PAD_CYCLES + N*DATA_W cycles of frame_n=0 (last bit has frame_n=1) after tx_start is sampled, plus 1 DONE cycle.

Test Plan:
- Single packet: push 0xA5 (last=1), tx_start with tx_addr=0x6.
  -> din reads 0,1,1,0 with frame_n=0, valid_n=1.
  -> 5 pad cycles of din=1.
  -> 8 cycles valid_n=0, din=1,0,1,0,0,1,0,1, frame_n=1 on the 8th.
  -> pkt_done one cycle later.
- Multi-byte: push 0x01, 0xFF, 0x80 (last on 0x80), tx_addr=0xF.
  -> 24 contiguous valid_n=0 cycles with correct LSB-first bits.
  -> frame_n=0 throughout until the final bit, where frame_n=1.
- Underrun: tx_start with an empty FIFO, then push 0x3C (last) 20 cycles later.
  -> frame_n stays 0 and valid_n stays 1 through the wait.
  -> data is sent once with no spurious valid_n=0 cycles.
- Overflow: push 17 bytes into DEPTH=16 without starting.
  -> wr_full=1 after the 16th push; the 17th is dropped; err_ovf=1.
  -> a subsequent packet sends exactly 16 bytes.
- Back-to-back: two queued packets, with tx_start asserted in the DONE cycle of the first.
  -> exactly one frame_n=1 cycle between the packets.
  -> a tx_start asserted while busy has no effect.
- Reset mid-payload: assert reset_n=0 during the 3rd data bit.
  -> frame_n=1, valid_n=1 asynchronously; FIFO empty; err_ovf=0.
  -> after release, a fresh packet transmits correctly.

Source files
------------

// File: rtl/router_port_tx.sv
// router_port_tx: byte FIFO plus serializer driving one router input lane (frame_n/valid_n/din)
module router_port_tx #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int PAD_CYCLES = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_full,
  input  logic              tx_start,
  input  logic [3:0]        tx_addr,
  output logic              tx_busy,
  output logic              pkt_done,
  output logic              err_ovf,
  output logic              frame_n,
  output logic              valid_n,
  output logic              din
);
  localparam int PW   = $clog2(DEPTH);
  localparam int NW   = $clog2(DEPTH + 1);
  localparam int CMAX = (DATA_W > PAD_CYCLES) ? ((DATA_W > 4) ? DATA_W : 4)
                                              : ((PAD_CYCLES > 4) ? PAD_CYCLES : 4);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DONE} state_t;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [NW-1:0]     count, count_nx;
  logic              push, pop;
  logic [DATA_W:0]   head;

  state_t            state, nstate;
  logic [CW-1:0]     cnt, ncnt;
  logic [3:0]        addr, naddr;
  logic [DATA_W-1:0] shift, nshift;
  logic              last, nlast, loaded, nloaded, boundary;
  logic              frame_d, valid_d, din_d, busy_d, done_d;

  // space is judged on the registered count, so a same-cycle pop never makes room
  assign push     = wr_en && (count < NW'(DEPTH));
  assign head     = mem[rp];
  assign count_nx = count + NW'(push) - NW'(pop);

  // FIFO storage, no reset needed since the pointers define validity
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= {wr_last, wr_data};
  end

  // FIFO pointers, occupancy, registered full flag and sticky overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      wr_full <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count   <= count_nx;
      wr_full <= count_nx == NW'(DEPTH);
      err_ovf <= err_ovf | (wr_en & ~push);
    end
  end

  // state register; outputs are registered from the values of the state being entered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      shift    <= '0;
      last     <= 1'b0;
      loaded   <= 1'b0;
      frame_n  <= 1'b1;
      valid_n  <= 1'b1;
      din      <= 1'b0;
      tx_busy  <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      addr     <= naddr;
      shift    <= nshift;
      last     <= nlast;
      loaded   <= nloaded;
      frame_n  <= frame_d;
      valid_n  <= valid_d;
      din      <= din_d;
      tx_busy  <= busy_d;
      pkt_done <= done_d;
    end
  end

  // next-state: a byte boundary either pops a whole entry or holds in underrun for a cycle
  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    naddr    = addr;
    nshift   = shift;
    nlast    = last;
    nloaded  = loaded;
    boundary = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE, DONE: begin
        nstate = tx_start ? ADDR : IDLE;
        if (tx_start) begin
          ncnt    = '0;
          naddr   = tx_addr;
          nloaded = 1'b0;
        end
      end
      ADDR: begin
        nstate = (cnt == CW'(3)) ? PAD : ADDR;
        ncnt   = (cnt == CW'(3)) ? '0 : cnt + CW'(1);
      end
      PAD: begin
        boundary = cnt == CW'(PAD_CYCLES - 1);
        ncnt     = cnt + CW'(1);
      end
      DATA: begin
        if (!loaded) boundary = 1'b1;
        else if (cnt != CW'(DATA_W - 1)) begin
          ncnt   = cnt + CW'(1);
          nshift = shift >> 1;
        end else if (last) nstate = DONE;
        else boundary = 1'b1;
      end
      default: nstate = IDLE;
    endcase
    if (boundary) begin
      nstate  = DATA;
      ncnt    = '0;
      pop     = count != '0;
      nloaded = pop;
      if (pop) begin
        nshift = head[DATA_W-1:0];
        nlast  = head[DATA_W];
      end
    end
  end

  // output decode of the entered state; frame_n rises on the final bit of a last-flagged byte
  always_comb begin
    frame_d = 1'b1;
    valid_d = 1'b1;
    din_d   = 1'b0;
    busy_d  = nstate inside {ADDR, PAD, DATA};
    done_d  = nstate == DONE;
    case (nstate)
      ADDR: begin
        frame_d = 1'b0;
        din_d   = naddr[ncnt[1:0]];
      end
      PAD: begin
        frame_d = 1'b0;
        din_d   = 1'b1;
      end
      DATA: begin
        frame_d = nloaded && nlast && (ncnt == CW'(DATA_W - 1));
        valid_d = !nloaded;
        din_d   = nloaded && nshift[0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_router_port_tx.sv
// tb_router_port_tx: table-driven packets plus hand sequences, checked cycle by cycle against a protocol model
module tb_router_port_tx;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n, wr_en, wr_last, wr_full, tx_start, tx_busy, pkt_done, err_ovf;
  logic       frame_n, valid_n, din;
  logic [7:0] wr_data;
  logic [3:0] tx_addr;

  typedef struct packed {logic f, v, d, done, busy;} obs_t;
  typedef struct {
    logic [3:0]      addr;
    int              n;
    logic [2:0][7:0] b;
    int              flow;
    int              vlow;
  } vec_t;

  obs_t       exp_q[$];
  logic [8:0] mq[$];
  vec_t       vt[4];
  int         checks = 0, errors = 0, flow, vlow;

  router_port_tx dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(wr_full), .tx_start(tx_start), .tx_addr(tx_addr), .tx_busy(tx_busy),
    .pkt_done(pkt_done), .err_ovf(err_ovf), .frame_n(frame_n), .valid_n(valid_n), .din(din)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(logic f, logic v, logic d, logic done, logic busy);
    return obs_t'({f, v, d, done, busy});
  endfunction

  task automatic push(input logic [7:0] b, input logic l);
    wr_en = 1'b1;
    wr_data = b;
    wr_last = l;
    if (mq.size() < DEPTH) mq.push_back({l, b});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic build(input logic [3:0] a, input int und);
    logic [8:0] e;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 1'b1, a[k], 1'b0, 1'b1));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < und; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    do begin
      e = mq.pop_front();
      for (int i = 0; i < 8; i++) exp_q.push_back(mk(e[8] && i == 7, 1'b0, e[i], 1'b0, 1'b1));
    end while (!e[8] && mq.size() > 0);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic start(input logic [3:0] a);
    tx_start = 1'b1;
    tx_addr = a;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic run_stream(input int push_at, input logic [8:0] pb, input int bogus_at,
                            input bit chain, input logic [3:0] chain_addr);
    obs_t e;
    int c = 1;
    flow = 0;
    vlow = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("stream c%0d", c), {27'b0, frame_n, valid_n, din, pkt_done, tx_busy}, {27'b0, e});
      flow += int'(!frame_n);
      vlow += int'(!valid_n);
      if (c == push_at - 1) begin
        wr_en = 1'b1;
        {wr_last, wr_data} = pb;
      end
      if (c == bogus_at) begin
        tx_start = 1'b1;
        tx_addr = 4'h3;
      end
      if (chain && exp_q.size() == 0) begin
        tx_start = 1'b1;
        tx_addr = chain_addr;
      end
      tick();
      wr_en = 1'b0;
      tx_start = 1'b0;
      c++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    tx_start = 1'b0;
    tx_addr = '0;
    vt[0] = '{4'h6, 1, {8'h00, 8'h00, 8'hA5}, 16, 8};
    vt[1] = '{4'hF, 3, {8'h80, 8'hFF, 8'h01}, 32, 24};
    vt[2] = '{4'h0, 2, {8'h00, 8'hFF, 8'h00}, 24, 16};
    vt[3] = '{4'h9, 1, {8'h00, 8'h00, 8'h5A}, 16, 8};
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rst frame_n", frame_n, 1);
    chk("rst valid_n", valid_n, 1);
    chk("rst din", din, 0);
    chk("rst tx_busy", tx_busy, 0);
    chk("rst pkt_done", pkt_done, 0);
    chk("rst err_ovf", err_ovf, 0);
    chk("rst wr_full", wr_full, 0);

    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < vt[t].n; j++) push(vt[t].b[j], j == vt[t].n - 1);
      build(vt[t].addr, 0);
      start(vt[t].addr);
      run_stream(0, '0, 0, 0, '0);
      chk($sformatf("vec%0d frame_low", t), flow, vt[t].flow);
      chk($sformatf("vec%0d valid_low", t), vlow, vt[t].vlow);
    end

    mq.push_back({1'b1, 8'h3C});
    build(4'h2, 11);
    start(4'h2);
    run_stream(20, {1'b1, 8'h3C}, 0, 0, '0);
    chk("underrun frame_low", flow, 27);
    chk("underrun valid_low", vlow, 8);

    for (int i = 0; i < 16; i++) begin
      push(8'h10 + 8'(i), i == 15);
      if (i == 14) chk("ovf full@15", wr_full, 0);
    end
    chk("ovf full@16", wr_full, 1);
    chk("ovf err before drop", err_ovf, 0);
    push(8'hEE, 1'b1);
    chk("ovf err after drop", err_ovf, 1);
    chk("ovf full after drop", wr_full, 1);
    build(4'hA, 0);
    start(4'hA);
    run_stream(0, '0, 0, 0, '0);
    chk("ovf valid_low", vlow, 128);
    chk("ovf full drained", wr_full, 0);

    push(8'h11, 1'b1);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    build(4'h4, 0);
    start(4'h4);
    run_stream(0, '0, 3, 1, 4'hB);
    build(4'hB, 0);
    run_stream(0, '0, 0, 0, '0);
    chk("b2b pkt2 valid_low", vlow, 16);

    push(8'hC3, 1'b0);
    push(8'h7E, 1'b1);
    build(4'h5, 0);
    start(4'h5);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("mid c%0d", c), {27'b0, frame_n, valid_n, din, pkt_done, tx_busy},
          {27'b0, exp_q.pop_front()});
      if (c < 12) tick();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async frame_n", frame_n, 1);
    chk("async valid_n", valid_n, 1);
    chk("async tx_busy", tx_busy, 0);
    chk("async err_ovf", err_ovf, 0);
    chk("async wr_full", wr_full, 0);
    exp_q.delete();
    mq.delete();
    tick();
    reset_n = 1'b1;
    tick();
    push(8'h96, 1'b1);
    build(4'hC, 0);
    start(4'hC);
    run_stream(0, '0, 0, 0, '0);
    chk("post-reset valid_low", vlow, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
